// File: rtl/slot_reel_bank.sv
// Bank of N_REELS digit counters that spin at a prescaled rate and stop one by one, lowest index first.
// When the last reel stops, the bank pulses o_done and reports whether all digits match on o_jackpot.
module slot_reel_bank #(
    parameter int N_REELS  = 3,
    parameter int SYMBOLS  = 10,
    parameter int DIGIT_W  = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_pause,
    output logic [N_REELS*DIGIT_W-1:0]   o_digits,
    output logic [N_REELS-1:0]           o_stopped,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_jackpot
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPIN,
        S_DONE
    } state_e;

    state_e                             state_q, state_d;
    logic [PW-1:0]                      presc_q, presc_d;
    logic [N_REELS-1:0][DIGIT_W-1:0]    digits_q, digits_d;
    logic [N_REELS-1:0]                 stopped_q, stopped_d;
    logic                               jackpot_q, jackpot_d;
    logic [N_REELS-1:0]                 stop_mask;
    logic                               tick;

    // One-hot select of the lowest-index reel that is still running.
    always_comb begin
        logic found;
        stop_mask = '0;
        found     = 1'b0;
        for (int i = 0; i < N_REELS; i++) begin
            if (!found && !stopped_q[i]) begin
                stop_mask[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        logic [DIGIT_W:0] sum;
        logic             all_eq;
        state_d   = state_q;
        presc_d   = presc_q;
        digits_d  = digits_q;
        stopped_d = stopped_q;
        jackpot_d = jackpot_q;
        tick      = 1'b0;
        sum       = '0;
        all_eq    = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_SPIN;
                    stopped_d = '0;
                    jackpot_d = 1'b0;
                    presc_d   = '0;
                end
            end
            S_SPIN: begin
                tick = (presc_q == PW'(TICK_DIV - 1)) && !i_pause;
                if (tick)
                    presc_d = '0;
                else if (!i_pause)
                    presc_d = presc_q + PW'(1);

                for (int i = 0; i < N_REELS; i++) begin
                    if (tick && !stopped_q[i] && !(i_stop && stop_mask[i])) begin
                        sum = {1'b0, digits_q[i]} + (DIGIT_W+1)'(1 + (i % (SYMBOLS - 1)));
                        if (sum >= (DIGIT_W+1)'(SYMBOLS))
                            sum = sum - (DIGIT_W+1)'(SYMBOLS);
                        digits_d[i] = sum[DIGIT_W-1:0];
                    end
                end

                if (i_stop)
                    stopped_d = stopped_q | stop_mask;

                // Jackpot is judged on the frozen values the reels will hold after this edge.
                if (&stopped_d) begin
                    state_d = S_DONE;
                    for (int i = 1; i < N_REELS; i++) begin
                        if (digits_d[i] != digits_d[0])
                            all_eq = 1'b0;
                    end
                    jackpot_d = all_eq;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            digits_q  <= '0;
            stopped_q <= '0;
            jackpot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            digits_q  <= digits_d;
            stopped_q <= stopped_d;
            jackpot_q <= jackpot_d;
        end
    end

    assign o_digits  = digits_q;
    assign o_stopped = stopped_q;
    assign o_busy    = (state_q == S_SPIN);
    assign o_done    = (state_q == S_DONE);
    assign o_jackpot = jackpot_q;

endmodule

// File: tb/tb_slot_reel_bank.sv
// Directed bench for slot_reel_bank: one instance at TICK_DIV=1 and one at TICK_DIV=4.
// Expected digit values are hand-derived from the per-reel strides 1, 2, 3 modulo 10.
module tb_slot_reel_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic        start4 = 1'b0, stop4 = 1'b0, pause4 = 1'b0;
    logic [11:0] d_digits, q_digits;
    logic [2:0]  d_stopped, q_stopped;
    logic        d_busy, d_done, d_jp;
    logic        q_busy, q_done, q_jp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    slot_reel_bank #(.N_REELS(3), .SYMBOLS(10), .DIGIT_W(4), .TICK_DIV(1)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_pause(pause),
        .o_digits(d_digits), .o_stopped(d_stopped), .o_busy(d_busy), .o_done(d_done),
        .o_jackpot(d_jp)
    );

    slot_reel_bank #(.N_REELS(3), .SYMBOLS(10), .DIGIT_W(4), .TICK_DIV(4)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_start(start4), .i_stop(stop4), .i_pause(pause4),
        .o_digits(q_digits), .o_stopped(q_stopped), .o_busy(q_busy), .o_done(q_done),
        .o_jackpot(q_jp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_vec++;
        if ({d_digits, d_stopped, d_busy, d_done, d_jp} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_dut1: got digits=%h stopped=%b busy=%b done=%b jp=%b, want all 0",
                     d_digits, d_stopped, d_busy, d_done, d_jp);
        end
        n_vec++;
        if ({q_digits, q_stopped, q_busy, q_done, q_jp} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_dut4: got digits=%h stopped=%b busy=%b done=%b jp=%b, want all 0",
                     q_digits, q_stopped, q_busy, q_done, q_jp);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_free_run();
        logic [11:0] exp_trace [1:5];
        exp_trace = '{12'h321, 12'h642, 12'h963, 12'h284, 12'h505};
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++;
        if (d_busy !== 1'b1 || d_digits !== 12'h000) begin
            n_err++;
            $display("FAIL start_edge: got busy=%b digits=%h, want busy=1 digits=000", d_busy, d_digits);
        end
        for (int e = 1; e <= 5; e++) begin
            step();
            n_vec++;
            if (d_digits !== exp_trace[e]) begin
                n_err++;
                $display("FAIL free_run_edge%0d: got digits=%h, want %h", e, d_digits, exp_trace[e]);
            end
        end
    endtask

    task automatic test_stop_sequence();
        logic [11:0] exp_dig [1:6];
        logic [2:0]  exp_stp [1:6];
        logic        stop_at [1:6];
        exp_dig = '{12'h321, 12'h641, 12'h961, 12'h261, 12'h561, 12'h561};
        exp_stp = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};
        stop_at = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            stop = stop_at[e];
            step();
            stop = 1'b0;
            n_vec++;
            if (d_digits !== exp_dig[e] || d_stopped !== exp_stp[e]) begin
                n_err++;
                $display("FAIL stop_seq_edge%0d: got digits=%h stopped=%b, want digits=%h stopped=%b",
                         e, d_digits, d_stopped, exp_dig[e], exp_stp[e]);
            end
        end
        n_vec++;
        if (d_done !== 1'b1 || d_busy !== 1'b0 || d_jp !== 1'b0) begin
            n_err++;
            $display("FAIL stop_seq_done: got done=%b busy=%b jp=%b, want done=1 busy=0 jp=0",
                     d_done, d_busy, d_jp);
        end
        step();
        n_vec++;
        if (d_done !== 1'b0 || d_busy !== 1'b0 || d_digits !== 12'h561 || d_jp !== 1'b0) begin
            n_err++;
            $display("FAIL stop_seq_idle: got done=%b busy=%b digits=%h jp=%b, want 0 0 561 0",
                     d_done, d_busy, d_digits, d_jp);
        end
    endtask

    task automatic test_jackpot();
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        stop4  = 1'b1;
        step();
        step();
        n_vec++;
        if (q_stopped !== 3'b011 || q_done !== 1'b0) begin
            n_err++;
            $display("FAIL jp_partial: got stopped=%b done=%b, want 011 0", q_stopped, q_done);
        end
        step();
        stop4 = 1'b0;
        n_vec++;
        if (q_stopped !== 3'b111 || q_done !== 1'b1 || q_jp !== 1'b1 || q_digits !== 12'h000) begin
            n_err++;
            $display("FAIL jp_done: got stopped=%b done=%b jp=%b digits=%h, want 111 1 1 000",
                     q_stopped, q_done, q_jp, q_digits);
        end
        step();
        step();
        step();
        n_vec++;
        if (q_jp !== 1'b1 || q_done !== 1'b0 || q_busy !== 1'b0) begin
            n_err++;
            $display("FAIL jp_hold: got jp=%b done=%b busy=%b, want 1 0 0", q_jp, q_done, q_busy);
        end
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        n_vec++;
        if (q_jp !== 1'b0 || q_busy !== 1'b1 || q_stopped !== 3'b000) begin
            n_err++;
            $display("FAIL jp_clear: got jp=%b busy=%b stopped=%b, want 0 1 000", q_jp, q_busy, q_stopped);
        end
    endtask

    task automatic test_reset_mid_spin();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_vec++;
        if (d_digits !== 12'h642) begin
            n_err++;
            $display("FAIL mid_spin_pre: got digits=%h, want 642", d_digits);
        end
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({d_digits, d_stopped, d_busy, d_done, d_jp} !== 18'h0) begin
            n_err++;
            $display("FAIL mid_spin_async: got digits=%h stopped=%b busy=%b, want 000 000 0",
                     d_digits, d_stopped, d_busy);
        end
        #1;
        rst  = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_vec++;
        if (d_stopped !== 3'b000 || d_busy !== 1'b0 || d_digits !== 12'h000) begin
            n_err++;
            $display("FAIL mid_spin_stop_lost: got stopped=%b busy=%b digits=%h, want 000 0 000",
                     d_stopped, d_busy, d_digits);
        end
    endtask

    task automatic test_ignored_inputs();
        stop  = 1'b1;
        pause = 1'b1;
        step();
        stop  = 1'b0;
        pause = 1'b0;
        n_vec++;
        if (d_stopped !== 3'b000 || d_busy !== 1'b0 || d_done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_stop: got stopped=%b busy=%b done=%b, want 000 0 0", d_stopped, d_busy, d_done);
        end
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        n_vec++;
        if (d_busy !== 1'b1 || d_digits !== 12'h321 || d_stopped !== 3'b000) begin
            n_err++;
            $display("FAIL spin_start: got busy=%b digits=%h stopped=%b, want 1 321 000",
                     d_busy, d_digits, d_stopped);
        end
    endtask

    task automatic test_pause();
        pause = 1'b1;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        n_vec++;
        if (d_digits !== 12'h321 || d_stopped !== 3'b001) begin
            n_err++;
            $display("FAIL pause_hold: got digits=%h stopped=%b, want 321 001", d_digits, d_stopped);
        end
        pause = 1'b0;
        step();
        n_vec++;
        if (d_digits !== 12'h641) begin
            n_err++;
            $display("FAIL pause_resume: got digits=%h, want 641", d_digits);
        end

        start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        pause4 = 1'b1;
        step();
        step();
        step();
        pause4 = 1'b0;
        step();
        n_vec++;
        if (q_digits !== 12'h000) begin
            n_err++;
            $display("FAIL presc_hold: got digits=%h, want 000", q_digits);
        end
        step();
        n_vec++;
        if (q_digits !== 12'h321) begin
            n_err++;
            $display("FAIL presc_tick: got digits=%h, want 321", q_digits);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stop_sequence();
        test_jackpot();
        test_reset_mid_spin();
        test_ignored_inputs();
        test_pause();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
